fc_neuron_mac: RTL and testbench
================================

# fc_neuron_mac

Sequential, parametrised fully-connected neuron for the FC layer datapath. It computes the signed fixed-point dot product of INPUT_SZ weight/input pairs plus a bias, time-multiplexed over LANES multipliers. It returns a rounded, saturated SIZE-bit result with a start/done handshake. It replaces the single-shot combinational neuron ALU wherever INPUT_SZ exceeds the multiplier budget.

## Interface
- SIZE, 16: word width, signed two's complement, Q(SIZE-1-PRECISION).PRECISION
- PRECISION, 11: fractional bits (0x0800 = 1.0 at defaults)
- INPUT_SZ, 4: number of weight/input pairs
- LANES, 2: parallel multipliers, 1..INPUT_SZ
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- clear  in  1  synchronous abort/zero
- weights  in  [INPUT_SZ-1:0][SIZE-1:0]  weight vector, captured on accepted start
- inputs  in  [INPUT_SZ-1:0][SIZE-1:0]  activation vector, captured on accepted start
- bias  in  SIZE  bias, captured on accepted start
- busy  out  1  high in ACCUM and FINISH
- done  out  1  one-cycle pulse, value valid
- value  out  SIZE  result, held until next done, clear or reset
- overflow  out  1  saturation occurred on last result, held with value

## Operation
- BEATS = ceil(INPUT_SZ/LANES).
- ACC_W = 2*SIZE + clog2(INPUT_SZ+1) + 1, signed.
- States: IDLE, ACCUM, FINISH.
- IDLE: start=1 latches operands and loads acc = sign-extended bias << PRECISION. Beat counter goes to 0, next state ACCUM.
- ACCUM: each cycle adds LANES products weights[k]*inputs[k] (full 2*SIZE signed) for k = beat*LANES + lane. Lanes with k >= INPUT_SZ contribute 0. After beat BEATS-1, next state FINISH.
- FINISH: r = (acc + 2^(PRECISION-1)) >>> PRECISION, i.e. round-half-up, arithmetic shift.
- Saturation: r above 2^(SIZE-1)-1 gives 0x7FF…F; r below -2^(SIZE-1) gives 0x800…0. overflow is 1 when either clamp applies, else 0.
- FINISH registers value/overflow, pulses done, returns to IDLE.
- start while busy: ignored, no queueing.
- clear (any state): next edge to IDLE; value=0, overflow=0, done=0; accumulator zeroed. Clear has priority over start in the same cycle.
- Operand changes after acceptance have no effect on the result.

## Timing
- Reset values: busy=0, done=0, value=0, overflow=0, state IDLE, acc=0, counter=0.
- Rst mid-operation aborts immediately; no done is produced.
- start sampled at edge T → busy=1 after T.
- done=1 and new value in the cycle after edge T+BEATS+1. Latency is BEATS+1 cycles; busy drops with done.
- Earliest next start: the cycle done is high (state is IDLE then). Back-to-back throughput is one result per BEATS+2 cycles.
- LANES = INPUT_SZ gives BEATS=1 and latency 2.

## Configuration
- FC_NEURON_RELU_EN defined: after saturation, negative results become 0x0000. overflow still reports saturation, including negative clamps.
- FC_NEURON_RELU_EN undefined: signed saturated result passed unchanged.

## Structure
- Shared package fc_pkg holds:
  - default SIZE/PRECISION constants
  - state enum typedef (IDLE, ACCUM, FINISH)
  - ACC_W computation function
  - saturate-and-round function, reused by other FC blocks
- Sub-module fc_mac_lane: one signed SIZE×SIZE multiplier with zero-gating for padded lanes. Instantiated LANES times via generate.

## Test plan
Defaults throughout unless noted.
- Basic: w={0x0800,0x0400,0,0}, x={0x1800,0x2000,0,0}, bias=0x0C00, start → done exactly 3 cycles after start edge, value=0x3400, overflow=0.
- Saturation: all w=all x=0x7FFF, bias=0x7FFF → value=0x7FFF, overflow=1. All w=0x7FFF, all x=0x8000 → value=0x8000, overflow=1; with FC_NEURON_RELU_EN → 0x0000, overflow=1.
- Sign/ReLU: w0=0xF800, x0=0x1000, others 0, bias 0 → value=0xF000 without macro, 0x0000 with macro.
- Rounding/padding: INPUT_SZ=3, LANES=2, w={0x0001,0,0}, x={0x0400,0,0}, bias 0 → value=0x0001, latency 3.
- Handshake: start repeated while busy ignored, single done. clear at first ACCUM cycle → no done, busy=0 and value=0x0000 next cycle.
- Reset: rst asserted mid-ACCUM with no clock edge → busy, done, value, overflow all 0 immediately.

Source files
------------

// File: rtl/fc_pkg.sv
// fc_pkg: shared definitions for the FC layer datapath blocks.
//   - default word width / fractional bits
//   - neuron sequencer state type
//   - accumulator width helper
//   - round-half-up + saturate helper shared by FC blocks
package fc_pkg;

  localparam int unsigned FC_SIZE      = 16;
  localparam int unsigned FC_PRECISION = 11;

  // Working widths for the generic round/saturate helper; callers cast in/out.
  localparam int unsigned FC_ACC_MAX = 128;
  localparam int unsigned FC_VAL_MAX = 64;

  typedef enum logic [1:0] {
    FC_IDLE   = 2'd0,
    FC_ACCUM  = 2'd1,
    FC_FINISH = 2'd2
  } fc_state_e;

  typedef struct packed {
    logic                  ovf;
    logic [FC_VAL_MAX-1:0] value;
  } fc_sat_t;

  // Accumulator width: full product, growth for n terms plus bias, one guard bit.
  function automatic int unsigned fc_acc_w(input int unsigned size, input int unsigned n);
    return 2 * size + $clog2(n + 1) + 1;
  endfunction

  // Round half up, arithmetic shift by prec, clamp to a signed size-bit word.
  function automatic fc_sat_t fc_round_sat(input logic signed [FC_ACC_MAX-1:0] acc,
                                           input int unsigned size,
                                           input int unsigned prec);
    logic signed [FC_ACC_MAX-1:0] half;
    logic signed [FC_ACC_MAX-1:0] r;
    logic signed [FC_ACC_MAX-1:0] hi;
    logic signed [FC_ACC_MAX-1:0] lo;
    fc_sat_t res;
    half = (prec == 0) ? '0 : (FC_ACC_MAX'(1) << (prec - 1));
    r    = (acc + half) >>> prec;
    hi   = (FC_ACC_MAX'(1) << (size - 1)) - FC_ACC_MAX'(1);
    lo   = -(FC_ACC_MAX'(1) << (size - 1));
    res.ovf   = 1'b0;
    res.value = FC_VAL_MAX'(r);
    if (r > hi) begin
      res.value = FC_VAL_MAX'(hi);
      res.ovf   = 1'b1;
    end else if (r < lo) begin
      res.value = FC_VAL_MAX'(lo);
      res.ovf   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// fc_mac_lane: one signed SIZE x SIZE multiplier, output forced to zero
// when the lane maps past the end of the operand vector.
//   en      in  lane carries a real operand pair
//   a, b    in  signed operands
//   prod_c  out full-width signed product (combinational)
module fc_mac_lane #(
  parameter int unsigned SIZE = 16
) (
  input  logic              en,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic [2*SIZE-1:0] prod_c
);

  localparam int unsigned PROD_W = 2 * SIZE;

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;

  assign a_ext  = PROD_W'($signed(a));
  assign b_ext  = PROD_W'($signed(b));
  assign prod_c = en ? (a_ext * b_ext) : '0;

endmodule

// File: rtl/fc_neuron_mac.sv
// fc_neuron_mac: sequential fully-connected neuron. Computes
//   sat(round((bias << PRECISION + sum_k w[k]*x[k]) >> PRECISION))
// using LANES multipliers over ceil(INPUT_SZ/LANES) beats.
// Ports:
//   clk, rst          clock, async active-high reset
//   start             request, accepted only in IDLE
//   clear             synchronous abort, zeroes result and accumulator
//   weights, inputs   operand vectors, captured on accepted start
//   bias              bias word, captured on accepted start
//   busy              high while ACCUM/FINISH
//   done              one-cycle pulse when value/overflow update
//   value, overflow   saturated result and clamp flag, held
// Build option: FC_NEURON_RELU_EN clamps negative results to zero after saturation.
module fc_neuron_mac
  import fc_pkg::*;
#(
  parameter int unsigned SIZE      = FC_SIZE,
  parameter int unsigned PRECISION = FC_PRECISION,
  parameter int unsigned INPUT_SZ  = 4,
  parameter int unsigned LANES     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          clear,
  input  logic [INPUT_SZ-1:0][SIZE-1:0] weights,
  input  logic [INPUT_SZ-1:0][SIZE-1:0] inputs,
  input  logic [SIZE-1:0]               bias,
  output logic                          busy,
  output logic                          done,
  output logic [SIZE-1:0]               value,
  output logic                          overflow
);

  localparam int unsigned BEATS  = (INPUT_SZ + LANES - 1) / LANES;
  localparam int unsigned ACC_W  = fc_acc_w(SIZE, INPUT_SZ);
  localparam int unsigned PROD_W = 2 * SIZE;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned IDX_W  = (INPUT_SZ > 1) ? $clog2(INPUT_SZ) : 1;

  fc_state_e                     state_q, state_d;
  logic [CNT_W-1:0]              beat_q, beat_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic [INPUT_SZ-1:0][SIZE-1:0] w_q, w_d;
  logic [INPUT_SZ-1:0][SIZE-1:0] x_q, x_d;
  logic [SIZE-1:0]               value_q, value_d;
  logic                          ovf_q, ovf_d;
  logic                          done_q, done_d;
  logic                          busy_q, busy_d;

  logic [LANES-1:0][SIZE-1:0]    lane_a;
  logic [LANES-1:0][SIZE-1:0]    lane_b;
  logic [LANES-1:0]              lane_en;
  logic [LANES-1:0][PROD_W-1:0]  lane_p;
  logic signed [ACC_W-1:0]       acc_sum;
  fc_sat_t                       sat_c;
  logic                          unused_sat;

  // Route operand pair k = beat*LANES + lane to each lane; padded lanes get zeros.
  always_comb begin
    int unsigned k;
    k       = 0;
    lane_a  = '0;
    lane_b  = '0;
    lane_en = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      k = 32'(beat_q) * LANES + l;
      if (k < INPUT_SZ) begin
        lane_en[l] = 1'b1;
        lane_a[l]  = w_q[IDX_W'(k)];
        lane_b[l]  = x_q[IDX_W'(k)];
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fc_mac_lane #(.SIZE(SIZE)) u_lane (
      .en     (lane_en[g]),
      .a      (lane_a[g]),
      .b      (lane_b[g]),
      .prod_c (lane_p[g])
    );
  end

  // Accumulator plus this beat's sign-extended products.
  always_comb begin
    acc_sum = acc_q;
    for (int unsigned l = 0; l < LANES; l++) begin
      acc_sum = acc_sum + ACC_W'($signed(lane_p[l]));
    end
  end

  assign sat_c      = fc_round_sat(FC_ACC_MAX'(acc_q), SIZE, PRECISION);
  assign unused_sat = ^sat_c;

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    acc_d   = acc_q;
    w_d     = w_q;
    x_d     = x_q;
    value_d = value_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    if (clear) begin
      state_d = FC_IDLE;
      beat_d  = '0;
      acc_d   = '0;
      value_d = '0;
      ovf_d   = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        FC_IDLE: begin
          busy_d = 1'b0;
          if (start) begin
            w_d     = weights;
            x_d     = inputs;
            acc_d   = ACC_W'($signed(bias)) <<< PRECISION;
            beat_d  = '0;
            busy_d  = 1'b1;
            state_d = FC_ACCUM;
          end
        end
        FC_ACCUM: begin
          acc_d = acc_sum;
          if (beat_q == CNT_W'(BEATS - 1)) begin
            state_d = FC_FINISH;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
        FC_FINISH: begin
          value_d = SIZE'(sat_c.value);
          ovf_d   = sat_c.ovf;
`ifdef FC_NEURON_RELU_EN
          if (value_d[SIZE-1]) begin
            value_d = '0;
          end
`else
`endif
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = FC_IDLE;
        end
        default: begin
          busy_d  = 1'b0;
          state_d = FC_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FC_IDLE;
      beat_q  <= '0;
      acc_q   <= '0;
      w_q     <= '0;
      x_q     <= '0;
      value_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      acc_q   <= acc_d;
      w_q     <= w_d;
      x_q     <= x_d;
      value_q <= value_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign value    = value_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_fc_neuron_mac.sv
// tb_fc_neuron_mac: directed + random checks of fc_neuron_mac against an
// integer-arithmetic reference. Instance A: defaults (4 pairs, 2 lanes).
// Instance B: 3 pairs on 2 lanes (one padded lane).
module tb_fc_neuron_mac;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;

  logic            start_a = 1'b0;
  logic [3:0][15:0] w_a = '0;
  logic [3:0][15:0] x_a = '0;
  logic [15:0]     bias_a = '0;
  logic            busy_a, done_a, ovf_a;
  logic [15:0]     value_a;

  logic            start_b = 1'b0;
  logic [2:0][15:0] w_b = '0;
  logic [2:0][15:0] x_b = '0;
  logic [15:0]     bias_b = '0;
  logic            busy_b, done_b, ovf_b;
  logic [15:0]     value_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fc_neuron_mac #(.SIZE(16), .PRECISION(11), .INPUT_SZ(4), .LANES(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .clear(clear),
    .weights(w_a), .inputs(x_a), .bias(bias_a),
    .busy(busy_a), .done(done_a), .value(value_a), .overflow(ovf_a)
  );

  fc_neuron_mac #(.SIZE(16), .PRECISION(11), .INPUT_SZ(3), .LANES(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .clear(clear),
    .weights(w_b), .inputs(x_b), .bias(bias_b),
    .busy(busy_b), .done(done_b), .value(value_b), .overflow(ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: Q4.11 dot product with plain 64-bit integer arithmetic.
  function automatic logic [16:0] model(input logic [3:0][15:0] w, input logic [3:0][15:0] x,
                                        input logic [15:0] b, input int n);
    longint acc;
    longint r;
    logic [15:0] v;
    logic o;
    acc = longint'($signed(b)) * 2048;
    for (int k = 0; k < n; k++) acc += longint'($signed(w[k])) * longint'($signed(x[k]));
    r = (acc + 1024) >>> 11;
    o = 1'b0;
    if (r > 32767) begin r = 32767; o = 1'b1; end
    else if (r < -32768) begin r = -32768; o = 1'b1; end
    v = 16'(r);
`ifdef FC_NEURON_RELU_EN
    if (r < 0) v = 16'h0000;
`endif
    return {o, v};
  endfunction

  function automatic logic [15:0] rnd_word();
    logic [31:0] t;
    t = $urandom;
    case ($urandom_range(0, 3))
      0:       return t[15:0];
      1:       return {{4{t[11]}}, t[11:0]};
      2:       return t[0] ? 16'h7FFF : 16'h8000;
      default: return {{8{t[7]}}, t[7:0]};
    endcase
  endfunction

  // Start one operation, scramble operands after acceptance, wait for done.
  task automatic run(input int sel, input logic [3:0][15:0] w, input logic [3:0][15:0] x,
                     input logic [15:0] b, output int lat, output logic [15:0] val,
                     output logic ovf);
    lat = -1;
    val = '0;
    ovf = 1'b0;
    if (sel == 0) begin w_a = w; x_a = x; bias_a = b; start_a = 1'b1; end
    else begin w_b = w[2:0]; x_b = x[2:0]; bias_b = b; start_b = 1'b1; end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    w_a = {$urandom, $urandom};
    x_a = {$urandom, $urandom};
    w_b = 48'({$urandom, $urandom});
    x_b = 48'({$urandom, $urandom});
    bias_a = 16'($urandom);
    bias_b = 16'($urandom);
    chk("busy_after_start", 32'(sel != 0 ? busy_b : busy_a), 32'(1));
    for (int c = 1; c <= 12 && lat < 0; c++) begin
      @(posedge clk); #1;
      if ((sel != 0) ? done_b : done_a) begin
        lat = c;
        val = (sel != 0) ? value_b : value_a;
        ovf = (sel != 0) ? ovf_b : ovf_a;
        chk("busy_with_done", 32'(sel != 0 ? busy_b : busy_a), 32'(0));
      end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(sel != 0 ? done_b : done_a), 32'(0));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][15:0] w, x;
    logic [15:0] b, val;
    logic ovf;
    logic [16:0] exp;
    int lat;
    int cnt;

    // Reset state
    #12;
    chk("rst_busy", 32'(busy_a), 32'(0));
    chk("rst_done", 32'(done_a), 32'(0));
    chk("rst_value", 32'(value_a), 32'(0));
    chk("rst_ovf", 32'(ovf_a), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic: 1.0*3.0 + 0.5*4.0 + 1.5 = 6.5
    w = '0; x = '0;
    w[0] = 16'h0800; w[1] = 16'h0400; x[0] = 16'h1800; x[1] = 16'h2000;
    run(0, w, x, 16'h0C00, lat, val, ovf);
    chk("basic_lat", 32'(lat), 32'(3));
    chk("basic_value", 32'(val), 32'h3400);
    chk("basic_ovf", 32'(ovf), 32'(0));

    // Positive saturation
    w = {4{16'h7FFF}}; x = {4{16'h7FFF}};
    run(0, w, x, 16'h7FFF, lat, val, ovf);
    chk("satp_value", 32'(val), 32'h7FFF);
    chk("satp_ovf", 32'(ovf), 32'(1));

    // Negative saturation
    x = {4{16'h8000}};
    run(0, w, x, 16'h0000, lat, val, ovf);
`ifdef FC_NEURON_RELU_EN
    chk("satn_value", 32'(val), 32'h0000);
`else
    chk("satn_value", 32'(val), 32'h8000);
`endif
    chk("satn_ovf", 32'(ovf), 32'(1));

    // Sign: -1.0 * 2.0
    w = '0; x = '0; w[0] = 16'hF800; x[0] = 16'h1000;
    run(0, w, x, 16'h0000, lat, val, ovf);
`ifdef FC_NEURON_RELU_EN
    chk("sign_value", 32'(val), 32'h0000);
`else
    chk("sign_value", 32'(val), 32'hF000);
`endif
    chk("sign_ovf", 32'(ovf), 32'(0));

    // Random on instance A
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < 4; k++) begin w[k] = rnd_word(); x[k] = rnd_word(); end
      b = rnd_word();
      exp = model(w, x, b, 4);
      run(0, w, x, b, lat, val, ovf);
      chk("rndA_lat", 32'(lat), 32'(3));
      chk("rndA_value", 32'(val), 32'(exp[15:0]));
      chk("rndA_ovf", 32'(ovf), 32'(exp[16]));
    end

    // Padded instance: round half up to 1, and -0.5 LSB rounds up to 0
    w = '0; x = '0; w[0] = 16'h0001; x[0] = 16'h0400;
    run(1, w, x, 16'h0000, lat, val, ovf);
    chk("pad_lat", 32'(lat), 32'(3));
    chk("pad_round_up", 32'(val), 32'h0001);
    w[0] = 16'hFFFF;
    run(1, w, x, 16'h0000, lat, val, ovf);
    chk("pad_round_neg_half", 32'(val), 32'h0000);
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 4; k++) begin w[k] = rnd_word(); x[k] = rnd_word(); end
      b = rnd_word();
      exp = model(w, x, b, 3);
      run(1, w, x, b, lat, val, ovf);
      chk("rndB_lat", 32'(lat), 32'(3));
      chk("rndB_value", 32'(val), 32'(exp[15:0]));
      chk("rndB_ovf", 32'(ovf), 32'(exp[16]));
    end

    // Back-to-back: restart in the done cycle, next done 4 cycles later
    w = '0; x = '0; w[0] = 16'h0800; x[0] = 16'h0800;
    w_a = w; x_a = x; bias_a = 16'h0000; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    lat = -1;
    for (int c = 1; c <= 12 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (done_a) lat = c;
    end
    chk("b2b_first_lat", 32'(lat), 32'(3));
    w_a[0] = 16'h1000; start_a = 1'b1;
    exp = model(w_a, x_a, 16'h0000, 4);
    @(posedge clk); #1;
    start_a = 1'b0;
    lat = -1;
    for (int c = 2; c <= 12 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (done_a) lat = c;
    end
    chk("b2b_period", 32'(lat), 32'(4));
    chk("b2b_value", 32'(value_a), 32'(exp[15:0]));

    // start held while busy: one done only
    w = {4{16'h7FFF}}; x = {4{16'h7FFF}};
    w_a = w; x_a = x; bias_a = 16'h7FFF; start_a = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start_a = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (done_a) cnt++;
      @(posedge clk); #1;
    end
    chk("held_start_dones", 32'(cnt), 32'(1));
    chk("held_start_value", 32'(value_a), 32'h7FFF);
    chk("held_start_ovf", 32'(ovf_a), 32'(1));

    // clear in first ACCUM cycle
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_busy", 32'(busy_a), 32'(0));
    chk("clear_value", 32'(value_a), 32'h0000);
    chk("clear_ovf", 32'(ovf_a), 32'(0));
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (done_a) cnt++;
      @(posedge clk); #1;
    end
    chk("clear_no_done", 32'(cnt), 32'(0));

    // clear beats start in the same cycle
    start_a = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; clear = 1'b0;
    chk("clear_prio_busy", 32'(busy_a), 32'(0));
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (done_a) cnt++;
      @(posedge clk); #1;
    end
    chk("clear_prio_no_done", 32'(cnt), 32'(0));

    // Async reset mid-ACCUM
    w = '0; x = '0;
    w[0] = 16'h0800; w[1] = 16'h0400; x[0] = 16'h1800; x[1] = 16'h2000;
    run(0, w, x, 16'h0C00, lat, val, ovf);
    chk("pre_rst_value", 32'(val), 32'h3400);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_a), 32'(0));
    chk("arst_done", 32'(done_a), 32'(0));
    chk("arst_value", 32'(value_a), 32'h0000);
    chk("arst_ovf", 32'(ovf_a), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (done_a) cnt++;
      @(posedge clk); #1;
    end
    chk("arst_no_done", 32'(cnt), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
